// File: rtl/ula_pipe.sv
// Two-stage pipelined ALU with status flags, accumulator chaining and
// valid/ready handshakes on both the operand and result sides.
module ula_pipe #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       select,
    input  logic             acc_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] saida,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_n,
    output logic             flag_v,
    output logic [WIDTH-1:0] acc
);

    localparam int unsigned MSB = WIDTH - 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_sel;
    logic             s1_accm;

    logic             s2_load;
    logic             accept;
    logic [WIDTH-1:0] opa;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;

    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_load;
    assign accept   = in_valid && in_ready;

    // Stage 1: operand capture; drains into stage 2 on s2_load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_sel   <= '0;
            s1_accm  <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= op_a;
            s1_b     <= op_b;
            s1_sel   <= select;
            s1_accm  <= acc_mode;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Accumulator is read here, at stage 2 compute time, so chained ops see
    // the result of the immediately preceding op without a hazard.
    always_comb begin
        opa   = s1_accm ? acc : s1_a;
        sum   = {1'b0, opa} + {1'b0, s1_b};
        diff  = {1'b0, opa} - {1'b0, s1_b};
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (s1_sel)
            OP_ADD: begin
                res   = sum[MSB:0];
                res_c = sum[WIDTH];
                res_v = (opa[MSB] == s1_b[MSB]) && (sum[MSB] != opa[MSB]);
            end
            OP_SUB: begin
                res   = diff[MSB:0];
                res_c = diff[WIDTH];
                res_v = (opa[MSB] != s1_b[MSB]) && (diff[MSB] != opa[MSB]);
            end
            OP_AND: res = opa & s1_b;
            OP_OR:  res = opa | s1_b;
            OP_XOR: res = opa ^ s1_b;
            OP_NOT: res = ~opa;
            OP_SHL: begin
                res   = {opa[MSB-1:0], 1'b0};
                res_c = opa[MSB];
            end
            OP_SHR: begin
                res   = {1'b0, opa[MSB:1]};
                res_c = opa[0];
            end
            default: begin
                res   = '0;
                res_c = 1'b0;
                res_v = 1'b0;
            end
        endcase
    end

    // Stage 2: result, flags and accumulator; held while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            saida     <= '0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            flag_n    <= 1'b0;
            flag_v    <= 1'b0;
            acc       <= '0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            saida     <= res;
            flag_z    <= (res == '0);
            flag_c    <= res_c;
            flag_n    <= res[MSB];
            flag_v    <= res_v;
            acc       <= res;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ula_pipe.sv
// Self-checking bench for ula_pipe: directed cases with literal expectations
// plus randomized traffic scored against an arithmetic reference model.
module tb_ula_pipe;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [2:0]   select;
    logic         acc_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] saida;
    logic         flag_z;
    logic         flag_c;
    logic         flag_n;
    logic         flag_v;
    logic [W-1:0] acc;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] r;
        logic         z;
        logic         c;
        logic         n;
        logic         v;
    } exp_t;

    exp_t         expq[$];
    logic [W-1:0] seen[$];
    logic [W-1:0] macc = '0;
    logic [W-1:0] t3[8];
    logic [W-1:0] t5[3];
    int           n0;

    ula_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .select(select), .acc_mode(acc_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .saida(saida), .flag_z(flag_z), .flag_c(flag_c),
        .flag_n(flag_n), .flag_v(flag_v), .acc(acc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int to_signed(input int x);
        return (x >= (1 << (W - 1))) ? x - (1 << W) : x;
    endfunction

    // Reference: plain integer arithmetic, overflow judged by signed range.
    function automatic exp_t model(input int a, input int b, input int s);
        int   mask;
        int   full;
        int   sr;
        exp_t e;
        mask = (1 << W) - 1;
        full = 0;
        e    = '0;
        case (s)
            0: begin
                full = a + b;
                e.c  = (full > mask);
                sr   = to_signed(a) + to_signed(b);
                e.v  = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
            end
            1: begin
                full = a - b;
                e.c  = (a < b);
                sr   = to_signed(a) - to_signed(b);
                e.v  = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
            end
            2: full = a & b;
            3: full = a | b;
            4: full = a ^ b;
            5: full = ~a;
            6: begin
                full = a * 2;
                e.c  = ((a >> (W - 1)) & 1) == 1;
            end
            default: begin
                full = a / 2;
                e.c  = (a % 2) == 1;
            end
        endcase
        e.r = W'(full & mask);
        e.z = (e.r == '0);
        e.n = e.r[W-1];
        return e;
    endfunction

    // Scoreboard: compare delivered results, then record newly accepted ops.
    always @(negedge clk) begin
        exp_t e;
        logic [W-1:0] a_eff;
        if (rst) begin
            expq.delete();
            macc = '0;
            check("reset_outputs", {out_valid, saida, flag_z, flag_c, flag_n, flag_v, acc}, 0);
        end else begin
            if (out_valid) begin
                if (expq.size() == 0) begin
                    check("spurious_out_valid", 32'(out_valid), 0);
                end else begin
                    e = expq[0];
                    check("sb_saida", 32'(saida), 32'(e.r));
                    check("sb_flags", {flag_z, flag_c, flag_n, flag_v}, {e.z, e.c, e.n, e.v});
                    check("sb_acc", 32'(acc), 32'(e.r));
                    if (out_ready) begin
                        void'(expq.pop_front());
                        seen.push_back(e.r);
                    end
                end
            end
            if (in_valid && in_ready) begin
                a_eff = acc_mode ? macc : op_a;
                e = model(int'(a_eff), int'(op_b), int'(select));
                macc = e.r;
                expq.push_back(e);
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] s, input logic m);
        int  n;
        bit  done;
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        select   = s;
        acc_mode = m;
        n        = 0;
        done     = 1'b0;
        while (!done && n < 50) begin
            done = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 32'(done), 1);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        t3 = '{4'b0000, 4'b0100, 4'b0010, 4'b1110, 4'b1100, 4'b0101, 4'b0100, 4'b0101};
        t5 = '{4'b0100, 4'b1010, 4'b1001};
        rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0;
        select = '0; acc_mode = 1'b0; out_ready = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_acc", 32'(acc), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("idle_in_ready", 32'(in_ready), 1);

        // 1: ADD with exact two-cycle latency
        send(4'b1100, 4'b0011, 3'b000, 1'b0);
        check("t1_latency_not_yet", 32'(out_valid), 0);
        tick();
        check("t1_out_valid", 32'(out_valid), 1);
        check("t1_saida", 32'(saida), 32'h F);
        check("t1_flags_zcnv", {flag_z, flag_c, flag_n, flag_v}, 4'b0010);
        check("t1_acc", 32'(acc), 32'h F);

        // 2: SUB with borrow, then ADD with signed overflow
        send(4'b1011, 4'b1111, 3'b001, 1'b0);
        tick();
        check("t2_sub_saida", 32'(saida), 32'b1100);
        check("t2_sub_flags_zcnv", {flag_z, flag_c, flag_n, flag_v}, 4'b0110);
        send(4'b0111, 4'b0001, 3'b000, 1'b0);
        tick();
        check("t2_add_saida", 32'(saida), 32'b1000);
        check("t2_add_flags_zcnv", {flag_z, flag_c, flag_n, flag_v}, 4'b0011);
        drain();

        // 3: all eight selects back to back at full throughput
        in_valid = 1'b1; op_a = 4'b1010; op_b = 4'b0110; acc_mode = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                select = 3'(i);
                check("t3_in_ready", 32'(in_ready), 1);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (i > 0) begin
                check("t3_out_valid", 32'(out_valid), 1);
                check("t3_saida", 32'(saida), 32'(t3[i-1]));
            end
        end
        drain();

        // 4: accumulator chain; op_a is junk once acc_mode is set
        in_valid = 1'b1; op_b = 4'b0001; select = 3'b000;
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) begin
                acc_mode = (i != 0);
                op_a     = (i == 0) ? 4'b0001 : 4'b1111;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (i > 0) check("t4_saida", 32'(saida), 32'(i + 1));
        end
        check("t4_acc", 32'(acc), 32'b0101);
        drain();

        // 5: backpressure holds two ops and stalls the third
        n0 = seen.size();
        out_ready = 1'b0;
        send(4'b0011, 4'b0001, 3'b000, 1'b0);
        send(4'b1111, 4'b0101, 3'b100, 1'b0);
        check("t5_full_in_ready", 32'(in_ready), 0);
        in_valid = 1'b1; op_a = 4'b0001; op_b = 4'b1000; select = 3'b011; acc_mode = 1'b0;
        repeat (2) begin
            tick();
            check("t5_stall_in_ready", 32'(in_ready), 0);
            check("t5_hold_saida", 32'(saida), 32'b0100);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check("t5_delivered_count", 32'(seen.size()), 32'(n0 + 3));
        for (int i = 0; i < 3; i++)
            if (seen.size() > n0 + i) check("t5_order", 32'(seen[n0+i]), 32'(t5[i]));

        // 6: async reset flushes two in-flight ops
        out_ready = 1'b0;
        send(4'b0001, 4'b0001, 3'b000, 1'b0);
        send(4'b0010, 4'b0010, 3'b000, 1'b0);
        rst = 1'b1;
        #1;
        check("t6_async_out_valid", 32'(out_valid), 0);
        check("t6_async_regs", {saida, flag_z, flag_c, flag_n, flag_v, acc}, 0);
        check("t6_in_ready", 32'(in_ready), 1);
        tick();
        rst = 1'b0;
        n0 = seen.size();
        out_ready = 1'b1;
        repeat (5) tick();
        check("t6_no_ghost_valid", 32'(out_valid), 0);
        check("t6_no_ghost_count", 32'(seen.size()), 32'(n0));

        // Random traffic with a mid-run reset
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc == 200) begin
                in_valid = 1'b0;
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            in_valid  = ($urandom_range(0, 9) < 7);
            op_a      = W'($urandom);
            op_b      = W'($urandom);
            select    = 3'($urandom);
            acc_mode  = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        drain();
        tick();
        check("final_queue_empty", 32'(expq.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
